// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential restoring divider.
//   state_t        : FSM encoding (IDLE, RUN)
//   DIV_WIDTH      : default divisor / quotient / remainder width
//   DIV_MAX_WIDTH  : largest width the all-ones constant covers
//   QUOT_ALL_ONES  : saturated quotient returned on divide-by-zero / overflow
package div_pkg;

   localparam int DIV_WIDTH     = 32;
   localparam int DIV_MAX_WIDTH = 64;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Sliced to the instance width by the user.
   localparam logic [DIV_MAX_WIDTH-1:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division iteration.
//   r        in  WIDTH+1  partial remainder (always < divisor on entry)
//   q        in  WIDTH    quotient / remaining-dividend shift register
//   divisor  in  WIDTH    unsigned denominator
//   r_next   out WIDTH+1  partial remainder after shift and conditional subtract
//   q_next   out WIDTH    shift register after shift, new quotient bit in [0]
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   r_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH+1:0] r_shift;
   logic             ge;

   // Shift {r,q} left by one; the extra top bit keeps every input bit in play
   // so the comparison is exact even though it is zero in normal operation.
   assign r_shift = {r, q[WIDTH-1]};
   assign ge      = (r_shift >= {2'b00, divisor});

   // NOTE: a continuous assign (or always_comb with every output written on
   // every path) is what keeps this block free of inferred latches.
   assign r_next = ge ? (r_shift[WIDTH:0] - {1'b0, divisor}) : r_shift[WIDTH:0];
   assign q_next = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- iterative restoring divider, one quotient bit per clock.
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        request, sampled only when idle
//   dividend     in   2*WIDTH  unsigned numerator
//   divisor      in   WIDTH    unsigned denominator
//   busy         out  1        iteration sequence running
//   done         out  1        one-cycle pulse, results and flags valid
//   quotient     out  WIDTH    registered result
//   remainder    out  WIDTH    registered result
//   div_by_zero  out  1        divisor was zero for the last result
//   overflow     out  1        quotient did not fit in WIDTH bits
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero,
   output logic                 overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      count_q;
   logic [WIDTH:0]     r_q;
   logic [WIDTH-1:0]   q_q;
   logic [WIDTH-1:0]   divisor_q;
   logic [WIDTH:0]     r_next;
   logic [WIDTH-1:0]   q_next;
   logic               exc_pend_q;   // exception result due on the next edge
   logic               exc_dbz_q;    // pending exception is divide-by-zero
   logic               accept;
   logic               last_step;
   logic               is_dbz;
   logic               is_ovf;

   // An exception result is in flight for one cycle without leaving IDLE;
   // new requests wait until it has been delivered.
   assign accept    = (state_q == IDLE) && start && !exc_pend_q;
   assign last_step = (state_q == RUN) && (count_q == CW'(1));
   assign is_dbz    = (divisor == '0);
   assign is_ovf    = (dividend[2*WIDTH-1:WIDTH] >= divisor);

   div_step #(.WIDTH(WIDTH)) u_step (
      .r       (r_q),
      .q       (q_q),
      .divisor (divisor_q),
      .r_next  (r_next),
      .q_next  (q_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output of the block.
      state_d = state_q;
      busy    = 1'b0;
      unique case (state_q)
         IDLE: if (accept && !is_dbz && !is_ovf) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_step) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         r_q         <= '0;
         q_q         <= '0;
         divisor_q   <= '0;
         exc_pend_q  <= 1'b0;
         exc_dbz_q   <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (exc_pend_q) begin
            exc_pend_q  <= 1'b0;
            quotient    <= QUOT_ALL_ONES[WIDTH-1:0];
            remainder   <= exc_dbz_q ? q_q : '0;
            div_by_zero <= exc_dbz_q;
            overflow    <= !exc_dbz_q;
            done        <= 1'b1;
         end else if (accept) begin
            divisor_q <= divisor;
            q_q       <= dividend[WIDTH-1:0];
            if (is_dbz || is_ovf) begin
               exc_pend_q <= 1'b1;
               exc_dbz_q  <= is_dbz;
            end else begin
               r_q     <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
               count_q <= CW'(WIDTH);
            end
         end else if (state_q == RUN) begin
            r_q     <= r_next;
            q_q     <= q_next;
            count_q <= count_q - 1'b1;
            if (last_step) begin
               quotient    <= q_next;
               remainder   <= r_next[WIDTH-1:0];
               div_by_zero <= 1'b0;
               overflow    <= 1'b0;
               done        <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- directed self-checking bench for seq_divider (WIDTH=32).
module tb_seq_divider;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [2*W-1:0] dividend = '0;
   logic [W-1:0]   divisor = '0;
   logic           busy, done, div_by_zero, overflow;
   logic [W-1:0]   quotient, remainder;

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request and follow it to done. Latency counts edges after the
   // accepting edge; busy is sampled in every cycle up to done.
   task automatic run_div(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf, input int exp_lat);
      int lat = 0;
      int busy_cycles = 0;
      int overlap = 0;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      dividend = '0;
      divisor  = '0;
      forever begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (busy && done) overlap++;
         if (done || lat > 100) break;
         @(posedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_cycles"}, 64'(busy_cycles), exp_lat == 1 ? 64'd0 : 64'(exp_lat));
      check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
      check({tag, " quotient"}, 64'(quotient), 64'(exp_q));
      check({tag, " remainder"}, 64'(remainder), 64'(exp_r));
      check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
      check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
      @(negedge clk);
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
      check({tag, " quotient_hold"}, 64'(quotient), 64'(exp_q));
   endtask

   initial begin
      int dones;
      int gap;

      // Reset state
      #2;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst quotient", 64'(quotient), 64'd0);
      check("rst remainder", 64'(remainder), 64'd0);
      check("rst flags", 64'({div_by_zero, overflow}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Main function and boundaries
      run_div("100/7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, W);
      run_div("maxprod", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, W);
      run_div("dbz", 64'h0000_0000_1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1);
      run_div("ovf", 64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1);
      run_div("hi=d-1", 64'h0000_0004_FFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0, W);
      run_div("1000/10", 64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, W);

      // Start ignored while running, then async reset mid-division
      dones = 0;
      @(negedge clk);
      dividend = 64'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(posedge clk);                       // edge 0
      #1 start = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         if (e == 10) begin
            @(negedge clk);
            dividend = 64'd9;
            divisor  = 32'd3;
            start    = 1'b1;
         end
         @(posedge clk);
         #1 start = 1'b0;
         if (done) dones++;
      end
      check("midrun busy", 64'(busy), 64'd1);
      check("midrun no_done", 64'(dones), 64'd0);
      rst_n = 1'b0;
      #1;
      check("async rst busy", 64'(busy), 64'd0);
      check("async rst quotient", 64'(quotient), 64'd0);
      check("async rst remainder", 64'(remainder), 64'd0);
      check("async rst flags", 64'({done, div_by_zero, overflow}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      check("post rst quiet", 64'(dones), 64'd0);
      run_div("9/3", 64'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, W);

      // Back-to-back with start held high; operands changed mid-run
      @(negedge clk);
      dividend = 64'd1000;
      divisor  = 32'd10;
      start    = 1'b1;
      @(posedge clk);
      #1 dividend = 64'd12345;
      divisor  = 32'd100;
      gap = 0;
      while (!done && gap < 100) begin
         @(negedge clk);
         gap++;
      end
      check("b2b first quotient", 64'(quotient), 64'd100);
      gap = 0;
      dones = 0;
      forever begin
         @(posedge clk);
         gap++;
         @(negedge clk);
         if (gap == 16) check("b2b first holds", 64'(quotient), 64'd100);
         if (done || gap > 100) break;
      end
      start = 1'b0;
      check("b2b gap", 64'(gap), 64'd33);
      check("b2b second quotient", 64'(quotient), 64'd123);
      check("b2b second remainder", 64'(remainder), 64'd45);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
